key_command_sequencer: RTL and testbench
========================================

# key_command_sequencer

Front-end stage ahead of the four-function calculator core. It turns the raw, bouncing push-buttons and the mode switch into clean one-hot operation commands (add, sub, mult, dvd, eq, clr). It holds each command stable across one rising edge of the slow calculator clock, so the core sees every press exactly once. It runs entirely on CLOCK_50 and treats the slow clock as a data input.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive CLOCK_50 cycles a key must differ from its debounced level before the debounced level flips (20 ms).
- CNT_W, default 20: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1: the only clock; all flops use its rising edge.
- RESET_N  in  1: asynchronous, active-low reset.
- KEY  in  4: raw buttons, active-low (0 = pressed), asynchronous.
- MODE_SW  in  1: raw mode switch (board SW[17]), asynchronous.
- SLOW_CLK  in  1: the calculator core's clock, sampled as data.
- add, sub, mult, dvd, eq, clr  out  1 each: one-hot command levels to the core.
- busy  out  1: a command is held and new presses are being ignored.

## Operation
- Synchronisers: KEY[3:0], MODE_SW and SLOW_CLK each pass through 2 flops.
  - Reset values: KEY sync = 1, MODE_SW sync = 0, SLOW_CLK sync = 0.
  - A third SLOW_CLK flop, reset 0, provides edge detection.
- Debounce, per key:
  - Each key has a debounced level (reset 1) and a counter (reset 0).
  - While the synced input equals the debounced level, the counter is 0.
  - While they differ, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced level flips and the counter clears.
  - A single cycle of agreement clears the counter, so bounces restart the count.
- Press event: the debounced level goes 1 -> 0. Release events generate nothing.
- Decode uses the synced MODE_SW value in the press-event cycle:
  - mode=0: KEY3 = add, KEY2 = sub, KEY1 = mult, KEY0 = dvd.
  - mode=1: KEY3 = eq, KEY0 = clr. KEY2 and KEY1 produce no command.
- Priority among press events in the same cycle: KEY3 > KEY2 > KEY1 > KEY0. Lower-priority events in that cycle are discarded.
- FSM states: IDLE, WAIT_FALL, WAIT_RISE. Reset state is IDLE.
  - IDLE: on a decoded command, register the one-hot command, set busy, go to WAIT_FALL.
  - WAIT_FALL: on a synced SLOW_CLK falling edge (flop2=0, flop3=1), go to WAIT_RISE.
  - WAIT_RISE: on a synced rising edge (flop2=1, flop3=0), clear all commands and busy, go to IDLE.
- Guarantee: the command is stable for at least the slow-clock low phase before the rising edge the core samples. The core therefore registers it exactly once.
- Press events while not in IDLE are dropped, not queued. Debouncing continues regardless of FSM state.
- Changing MODE_SW while a command is held has no effect on that command.
- A stuck (held) key yields one command only. Another command requires a release and a new press.

## Timing
- Reset values: all six commands = 0, busy = 0, FSM in IDLE, every debounced level = 1.
- Reset asserted mid-hold drops the held command immediately; it is not re-issued.
- Press latency: raw KEY low and stable from edge N gives debounced = 0 at edge N+2+DEBOUNCE_CYCLES. The command and busy go high at edge N+3+DEBOUNCE_CYCLES.
- Release latency: the command clears 3 CLOCK_50 edges after the raw SLOW_CLK rising edge (2 sync + 1 register), measured in WAIT_RISE.
- Maximum hold time: under 1.5 slow-clock periods plus 6 CLOCK_50 cycles.
- At most one of the six commands is high in any cycle.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, CNT_W=3, SLOW_CLK period 40 CLOCK_50 cycles.
- KEY=1110 (KEY0 low) held clean from edge 10, mode=0 -> dvd=1 and busy=1 at edge 17; dvd clears 3 cycles after the next SLOW_CLK rise that follows a fall; no other output ever high.
- KEY3 toggles low/high every 2 cycles for 20 cycles, then goes high -> no command. Then held low 10 cycles with mode=1 -> eq pulse held across exactly one SLOW_CLK rise.
- KEY3 and KEY0 pressed in the same cycle, mode=0 -> add only; dvd never asserts.
- KEY2 pressed with mode=1 -> no command, busy stays 0.
- sub held; KEY1 pressed and debounced during WAIT_RISE -> mult never asserts, sub clears normally.
- RESET_N pulsed low during WAIT_FALL with add=1 -> add=0 and busy=0 asynchronously. After release, keys still held low produce no command until released and re-pressed.

Source files
------------

// File: rtl/key_command_sequencer.sv
// key_command_sequencer
//   Turns the raw, bouncing calculator push-buttons and mode switch into clean
//   one-hot commands. Each command is held until the calculator core's slow
//   clock has gone low and then risen once, so the core samples it exactly once.
//   Everything runs on CLOCK_50; SLOW_CLK is sampled as data.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   KEY[3:0]   in   raw buttons, active-low, asynchronous
//   MODE_SW    in   raw mode switch, asynchronous
//   SLOW_CLK   in   calculator core clock, treated as data
//   add..clr   out  one-hot command levels to the core
//   busy       out  a command is held; new presses are dropped
//
// FSM states
//   state     | meaning
//   IDLE      | no command held, accepting presses
//   WAIT_FALL | command held, waiting for synced SLOW_CLK to fall
//   WAIT_RISE | command held, waiting for synced SLOW_CLK to rise, then release
module key_command_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    input  logic       MODE_SW,
    input  logic       SLOW_CLK,
    output logic       add,
    output logic       sub,
    output logic       mult,
    output logic       dvd,
    output logic       eq,
    output logic       clr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        WAIT_RISE = 2'd2
    } state_t;

    // one-hot command encodings, ordered {add, sub, mult, dvd, eq, clr}
    localparam logic [5:0] CMD_ADD  = 6'b100000;
    localparam logic [5:0] CMD_SUB  = 6'b010000;
    localparam logic [5:0] CMD_MULT = 6'b001000;
    localparam logic [5:0] CMD_DVD  = 6'b000100;
    localparam logic [5:0] CMD_EQ   = 6'b000010;
    localparam logic [5:0] CMD_CLR  = 6'b000001;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]             key_s1_q, key_s2_q;
    logic                   mode_s1_q, mode_s2_q;
    logic                   slow_s1_q, slow_s2_q, slow_s3_q;
    logic [1:0]             settle_q, settle_d;
    logic [3:0]             arm_q, arm_d;
    logic [3:0]             deb_q, deb_d;
    logic [3:0]             deb_prev_q;
    logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]             press;
    logic [5:0]             cmd_dec;
    logic                   settled;
    logic                   slow_fall, slow_rise;

    state_t                 state_q;
    logic [5:0]             cmd_q;
    logic                   busy_q;

    // Synchroniser outputs only carry real pin values two edges after reset
    // release; until then the reset values could look like a released key.
    assign settled = (settle_q == 2'd2);

    always_comb begin
        settle_d = settled ? settle_q : settle_q + 2'd1;
        for (int k = 0; k < 4; k++) begin
            deb_d[k] = deb_q[k];
            cnt_d[k] = '0;
            if (key_s2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    deb_d[k] = ~deb_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        // A key only becomes able to issue a command once it has been seen
        // released after reset, so a key held through reset stays silent.
        arm_d = arm_q | ({4{settled}} & key_s2_q & deb_q);
    end

    // press event: debounced level went 1 -> 0 on an armed key
    assign press = arm_q & deb_prev_q & ~deb_q;

    always_comb begin
        cmd_dec = '0;
        if (press[3]) begin
            cmd_dec = mode_s2_q ? CMD_EQ : CMD_ADD;
        end else if (press[2]) begin
            cmd_dec = mode_s2_q ? 6'b000000 : CMD_SUB;
        end else if (press[1]) begin
            cmd_dec = mode_s2_q ? 6'b000000 : CMD_MULT;
        end else if (press[0]) begin
            cmd_dec = mode_s2_q ? CMD_CLR : CMD_DVD;
        end
    end

    assign slow_fall = ~slow_s2_q & slow_s3_q;
    assign slow_rise = slow_s2_q & ~slow_s3_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1_q   <= 4'hF;
            key_s2_q   <= 4'hF;
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            slow_s1_q  <= 1'b0;
            slow_s2_q  <= 1'b0;
            slow_s3_q  <= 1'b0;
            settle_q   <= 2'd0;
            arm_q      <= 4'h0;
            deb_q      <= 4'hF;
            deb_prev_q <= 4'hF;
            cnt_q      <= '0;
        end else begin
            key_s1_q   <= KEY;
            key_s2_q   <= key_s1_q;
            mode_s1_q  <= MODE_SW;
            mode_s2_q  <= mode_s1_q;
            slow_s1_q  <= SLOW_CLK;
            slow_s2_q  <= slow_s1_q;
            slow_s3_q  <= slow_s2_q;
            settle_q   <= settle_d;
            arm_q      <= arm_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|cmd_dec) begin
                        cmd_q   <= cmd_dec;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (slow_fall) begin
                        state_q <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (slow_rise) begin
                        cmd_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cmd_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {add, sub, mult, dvd, eq, clr} = cmd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_key_command_sequencer.sv
module tb_key_command_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic [3:0] KEY      = 4'hF;
    logic       MODE_SW  = 1'b0;
    logic       SLOW_CLK = 1'b0;
    logic       add, sub, mult, dvd, eq, clr, busy;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] forbid = 6'b000000;
    bit         mon_en = 1'b0;

    logic [5:0] cmds;
    logic [6:0] obs;
    assign cmds = {add, sub, mult, dvd, eq, clr};
    assign obs  = {busy, cmds};

    localparam logic [6:0] S_IDLE = 7'b0000000;
    localparam logic [6:0] S_ADD  = 7'b1100000;
    localparam logic [6:0] S_SUB  = 7'b1010000;
    localparam logic [6:0] S_DVD  = 7'b1000100;
    localparam logic [6:0] S_EQ   = 7'b1000010;

    key_command_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .KEY     (KEY),
        .MODE_SW (MODE_SW),
        .SLOW_CLK(SLOW_CLK),
        .add     (add),
        .sub     (sub),
        .mult    (mult),
        .dvd     (dvd),
        .eq      (eq),
        .clr     (clr),
        .busy    (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // edge counter and slow clock: 40 CLOCK_50 cycles per period,
    // rises just after edges 20, 60, ... and falls just after edges 40, 80, ...
    always @(posedge CLOCK_50) begin
        cyc = cyc + 1;
        #1 SLOW_CLK = ((cyc / 20) % 2) == 1;
    end

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, observed, expected);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            check("onehot", 7'($onehot0(cmds)), 7'd1);
            check("forbidden_cmd", {1'b0, cmds & forbid}, 7'd0);
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic goto(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        #1 RESET_N = 1'b0;
        #2;
        mon_en = 1'b1;
        check("reset_state", obs, S_IDLE);
        goto(2);
        RESET_N = 1'b1;

        // clean KEY0 press, mode 0 -> dvd
        goto(10);
        forbid = 6'b111011;
        KEY = 4'b1110;
        goto(16); check("t1_pre", obs, S_IDLE);
        goto(17); check("t1_dvd", obs, S_DVD);
        goto(30); MODE_SW = 1'b1;
        goto(62); check("t1_hold_mode_change", obs, S_DVD);
        goto(63); check("t1_clear", obs, S_IDLE);
        MODE_SW = 1'b0;
        KEY = 4'hF;

        // bouncing KEY3 yields nothing
        goto(80);
        forbid = 6'b111111;
        for (int i = 0; i < 10; i++) begin
            goto(80 + 2 * i);
            KEY = (i % 2 == 0) ? 4'b0111 : 4'b1111;
        end
        goto(100);
        KEY = 4'hF;
        check("t2_bounce", obs, S_IDLE);
        MODE_SW = 1'b1;
        goto(103); check("t2_bounce_late", obs, S_IDLE);

        // KEY3 held 10 cycles, mode 1 -> eq across one slow rise
        goto(104);
        forbid = 6'b111101;
        KEY = 4'b0111;
        goto(110); check("t2_eq_pre", obs, S_IDLE);
        goto(111); check("t2_eq", obs, S_EQ);
        goto(114); KEY = 4'hF;
        goto(142); check("t2_eq_hold", obs, S_EQ);
        goto(143); check("t2_eq_clear", obs, S_IDLE);

        // KEY3 and KEY0 together, mode 0 -> add only
        goto(150);
        MODE_SW = 1'b0;
        forbid = 6'b011111;
        goto(160); KEY = 4'b0110;
        goto(166); check("t3_pre", obs, S_IDLE);
        goto(167); check("t3_add", obs, S_ADD);
        goto(222); check("t3_hold", obs, S_ADD);
        goto(223); check("t3_clear", obs, S_IDLE);
        goto(225); KEY = 4'hF;

        // KEY2 in mode 1 -> nothing
        goto(235);
        MODE_SW = 1'b1;
        forbid = 6'b111111;
        goto(240); KEY = 4'b1011;
        for (int k = 246; k <= 255; k++) begin
            goto(k);
            check("t4_no_cmd", obs, S_IDLE);
        end
        KEY = 4'hF;
        goto(265); MODE_SW = 1'b0;

        // sub held; KEY1 pressed during WAIT_RISE is dropped
        forbid = 6'b101111;
        goto(280); KEY = 4'b1011;
        goto(286); check("t5_pre", obs, S_IDLE);
        goto(287); check("t5_sub", obs, S_SUB);
        goto(325); KEY = 4'b1001;
        goto(342); check("t5_hold", obs, S_SUB);
        goto(343); check("t5_clear", obs, S_IDLE);
        for (int k = 344; k <= 360; k += 4) begin
            goto(k);
            check("t5_no_requeue", obs, S_IDLE);
        end
        KEY = 4'hF;

        // reset mid-hold drops add; held key silent until re-pressed
        forbid = 6'b011111;
        goto(380); KEY = 4'b0111;
        goto(387); check("t6_add", obs, S_ADD);
        goto(391); check("t6_add_hold", obs, S_ADD);
        goto(392);
        RESET_N = 1'b0;
        #1 check("t6_async_reset", obs, S_IDLE);
        goto(394);
        RESET_N = 1'b1;
        forbid = 6'b111111;
        for (int k = 395; k <= 420; k += 5) begin
            goto(k);
            check("t6_held_silent", obs, S_IDLE);
        end
        KEY = 4'hF;
        goto(440);
        forbid = 6'b011111;
        KEY = 4'b0111;
        goto(446); check("t6_repress_pre", obs, S_IDLE);
        goto(447); check("t6_repress_add", obs, S_ADD);
        goto(502); check("t6_repress_hold", obs, S_ADD);
        goto(503); check("t6_repress_clear", obs, S_IDLE);
        goto(505); KEY = 4'hF;
        goto(520);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
